hdlc_tx_framer: RTL and testbench
=================================

// Module: hdlc_tx_framer
// PURPOSE
//  Bit-level HDLC transmit framer; the transmit end of the serial link whose receive side is Rx/RxD.
//  Pulls bytes from the TX buffer over a read handshake and serialises them LSB first on Tx.
//  Wraps the data in opening/closing flags (0x7E) and inserts a zero after five consecutive 1s.
//  Emits the abort pattern on request and idles at all-ones between frames.
// PARAMETERS
//  MAX_BYTES  128      max data bytes per frame; frame is closed after this many bytes
//  CRC_INIT   16'hFFFF FCS register preset (used only with HDLC_FCS_EN)
// PORTS
//  Clk             in   1  system clock, all logic on posedge
//  Rst             in   1  asynchronous, active-low reset
//  Tx_Enable       in   1  1-cycle start request; ignored unless IDLE and Tx_DataAvail=1
//  Tx_DataAvail    in   1  TX buffer holds at least one unread byte
//  Tx_Data         in   8  byte from TX buffer, valid the cycle after Tx_RdBuff
//  Tx_RdBuff       out  1  1-cycle pop strobe to TX buffer
//  Tx_AbortFrame   in   1  abort request (level, edge-detected internally)
//  Tx              out  1  serial line, registered
//  Tx_ValidFrame   out  1  high from first opening-flag bit to last closing-flag bit
//  Tx_Done         out  1  1-cycle pulse with last closing-flag bit on Tx
//  Tx_AbortedTrans out  1  set when an abort pattern has been sent; cleared at next frame start
// BEHAVIOUR
//  Reset (Rst=0, async): state IDLE; Tx=1, Tx_RdBuff=0, Tx_ValidFrame=0, Tx_Done=0,
//   Tx_AbortedTrans=0; bit index, ones counter, byte counter cleared; FCS=CRC_INIT.
//  One bit per Clk. Bit index 0..7 per symbol; symbol content LSB first.
//  States: IDLE -> FLAG_OPEN -> DATA -> [FCS] -> FLAG_CLOSE -> IDLE; any non-IDLE -> ABORT -> IDLE.
//  IDLE: Tx=1. Tx_Enable && Tx_DataAvail at cycle n -> first flag bit (0) on Tx at n+1,
//   Tx_ValidFrame=1 at n+1, Tx_AbortedTrans cleared at n+1, Tx_RdBuff pulses at n+1.
//  FLAG_OPEN/FLAG_CLOSE: send 0,1,1,1,1,1,1,0; no zero insertion; ones counter cleared.
//  DATA: Tx_RdBuff pulses when bit index=6 of current symbol if Tx_DataAvail=1 and
//   byte count<MAX_BYTES; byte latched at index 7. No pop at boundary -> leave DATA.
//  Zero insertion (DATA, FCS): after five consecutive 1s on Tx, next cycle Tx=0 and bit
//   index stalls one cycle; ones counter runs across byte boundaries; inserted 0 resets it.
//   Fetch timing is index-based, so stalls shift the pop strobe with the stream.
//  Abort: rising Tx_AbortFrame while Tx_ValidFrame=1 -> from next cycle send 0 then seven 1s
//   (8 cycles), Tx_ValidFrame=0 on the first of these, Tx_AbortedTrans=1 on the last,
//   then IDLE. No Tx_Done. Abort in IDLE ignored. Abort has priority over Tx_Enable.
//  Tx_Done and Tx_ValidFrame fall together: Tx_Done=1 on last closing-flag bit only.
//  Tx_Enable while busy: ignored (no queueing).
//  Byte counter is 8-bit; MAX_BYTES>255 is illegal (elaboration $error).
// CONFIGURATION
//  HDLC_FCS_EN defined: CRC-16-CCITT (x^16+x^12+x^5+1, reflected, preset CRC_INIT) over
//   data bits before zero insertion; after last byte, state FCS sends ~CRC, 16 bits LSB
//   first, with zero insertion, then FLAG_CLOSE.
//  HDLC_FCS_EN undefined: no FCS state/logic; DATA goes directly to FLAG_CLOSE.
// TESTING
//  T1 reset: Rst=0 mid-DATA -> Tx=1, Tx_ValidFrame=0, Tx_RdBuff=0 immediately; idle ones after release.
//  T2 1 byte 0x81, no FCS: Tx_Enable -> Tx = 01111110 10000001 01111110, then 1s;
//   exactly one Tx_RdBuff; Tx_Done on cycle 24 after Tx_Enable.
//  T3 zero insertion: byte 0xFF then 0x01 -> data stream 11111 0 111 1 0000000 (17 bits);
//   frame is 1 cycle longer than T2 + one byte.
//  T4 FCS (HDLC_FCS_EN): bytes 0x01,0x02 -> FCS bytes on Tx match reference CRC model;
//   RTL receive side on loopback reports Rx_FCSerr=0, Rx_FrameSize=2.
//  T5 abort: Tx_AbortFrame rises during 2nd data byte -> Tx = 0 then 1111111, Tx_ValidFrame
//   falls, Tx_AbortedTrans=1, no Tx_Done; next Tx_Enable clears Tx_AbortedTrans.
//  T6 length: buffer holds 130 bytes, MAX_BYTES=128 -> exactly 128 Tx_RdBuff pulses, then closing flag.

Source files
------------

// File: rtl/hdlc_tx_framer.sv
// rtl/hdlc_tx_framer.sv - bit-level HDLC transmit framer; optional FCS when HDLC_FCS_EN is defined
module hdlc_tx_framer #(
  parameter int          MAX_BYTES = 128,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic       Tx_DataAvail,
  input  logic [7:0] Tx_Data,
  output logic       Tx_RdBuff,
  input  logic       Tx_AbortFrame,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans
);

  // The byte counter is 8 bits wide, so larger frame limits cannot be honoured.
  if (MAX_BYTES > 255) begin : g_bad_max_bytes
    $error("hdlc_tx_framer: MAX_BYTES must not exceed 255");
  end

  localparam logic [7:0] LP_FLAG = 8'h7E;
  localparam logic [7:0] LP_MAX  = 8'(MAX_BYTES);

`ifdef HDLC_FCS_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FLAG_OPEN, S_DATA, S_FCS, S_FLAG_CLOSE, S_ABORT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FLAG_OPEN, S_DATA, S_FLAG_CLOSE, S_ABORT
  } state_t;
`endif

  state_t      r_state, w_nxt_state;
  logic [2:0]  r_idx, w_nxt_idx;        // index of the symbol bit currently on Tx
  logic [2:0]  r_ones, w_nxt_ones;      // consecutive ones currently on the line
  logic [6:0]  r_shift, w_nxt_shift;    // remaining bits of the current symbol
  logic        r_have_next, w_nxt_have; // a byte was popped for the next symbol
  logic [7:0]  r_bytes, w_nxt_bytes;    // bytes popped in this frame
  logic        r_tx, w_nxt_tx;
  logic        r_rd, w_nxt_rd;
  logic        r_valid, w_nxt_valid;
  logic        r_done, w_nxt_done;
  logic        r_aborted, w_nxt_aborted;
  logic        r_abort_q;
  logic        r_rd_d;
  logic [7:0]  r_hold;
  logic [7:0]  w_byte;
  logic [2:0]  w_idx_inc;
  logic        w_abort_req;
  logic        w_can_pop;

`ifdef HDLC_FCS_EN
  logic [15:0] r_crc, w_nxt_crc;
  logic        r_fcs_hi, w_nxt_fcs_hi;  // second FCS byte is being sent

  // Reflected CRC-16-CCITT update over one byte, LSB first.
  function automatic logic [15:0] f_crc_byte(input logic [15:0] i_crc, input logic [7:0] i_byte);
    logic [15:0] v;
    v = i_crc ^ {8'h00, i_byte};
    for (int i = 0; i < 8; i++) begin
      v = v[0] ? ((v >> 1) ^ 16'h8408) : (v >> 1);
    end
    return v;
  endfunction
`else
  logic w_unused_crc;
  assign w_unused_crc = ^CRC_INIT;
`endif

  // The buffer presents the byte only in the cycle after the pop, so it is held until the symbol boundary.
  assign w_byte      = r_rd_d ? Tx_Data : r_hold;
  assign w_idx_inc   = r_idx + 3'd1;
  assign w_abort_req = Tx_AbortFrame && !r_abort_q && r_valid;
  assign w_can_pop   = Tx_DataAvail && (r_bytes < LP_MAX);

  assign Tx              = r_tx;
  assign Tx_RdBuff       = r_rd;
  assign Tx_ValidFrame   = r_valid;
  assign Tx_Done         = r_done;
  assign Tx_AbortedTrans = r_aborted;

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Next-state and next-bit decision; every line-visible output is registered from here.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_idx     = r_idx;
    w_nxt_tx      = 1'b1;
    w_nxt_shift   = r_shift;
    w_nxt_have    = r_have_next;
    w_nxt_bytes   = r_bytes;
    w_nxt_rd      = 1'b0;
    w_nxt_valid   = r_valid;
    w_nxt_done    = 1'b0;
    w_nxt_aborted = r_aborted;
    w_nxt_ones    = 3'd0;
`ifdef HDLC_FCS_EN
    w_nxt_crc     = r_crc;
    w_nxt_fcs_hi  = r_fcs_hi;
`endif
    if (w_abort_req) begin
      w_nxt_state = S_ABORT;
      w_nxt_idx   = 3'd0;
      w_nxt_tx    = 1'b0;
      w_nxt_valid = 1'b0;
      w_nxt_have  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Tx_Enable && Tx_DataAvail) begin
            w_nxt_state   = S_FLAG_OPEN;
            w_nxt_idx     = 3'd0;
            w_nxt_tx      = LP_FLAG[0];
            w_nxt_valid   = 1'b1;
            w_nxt_aborted = 1'b0;
            w_nxt_rd      = 1'b1;
            w_nxt_bytes   = 8'd1;
`ifdef HDLC_FCS_EN
            w_nxt_crc     = CRC_INIT;
            w_nxt_fcs_hi  = 1'b0;
`endif
          end
        end
        S_FLAG_OPEN: begin
          if (r_idx != 3'd7) begin
            w_nxt_idx = w_idx_inc;
            w_nxt_tx  = LP_FLAG[w_idx_inc];
          end else begin
            w_nxt_state = S_DATA;
            w_nxt_idx   = 3'd0;
            w_nxt_shift = w_byte[7:1];
            w_nxt_tx    = w_byte[0];
            w_nxt_have  = 1'b0;
`ifdef HDLC_FCS_EN
            w_nxt_crc   = f_crc_byte(r_crc, w_byte);
`endif
          end
        end
        S_DATA: begin
          if (r_ones == 3'd5) begin
            w_nxt_tx = 1'b0;
          end else if (r_idx != 3'd7) begin
            w_nxt_idx   = w_idx_inc;
            w_nxt_tx    = r_shift[0];
            w_nxt_shift = {1'b0, r_shift[6:1]};
            if (w_idx_inc == 3'd6 && w_can_pop) begin
              w_nxt_rd    = 1'b1;
              w_nxt_bytes = r_bytes + 8'd1;
              w_nxt_have  = 1'b1;
            end
          end else if (r_have_next) begin
            w_nxt_idx   = 3'd0;
            w_nxt_shift = w_byte[7:1];
            w_nxt_tx    = w_byte[0];
            w_nxt_have  = 1'b0;
`ifdef HDLC_FCS_EN
            w_nxt_crc   = f_crc_byte(r_crc, w_byte);
`endif
          end else begin
`ifdef HDLC_FCS_EN
            w_nxt_state  = S_FCS;
            w_nxt_idx    = 3'd0;
            w_nxt_shift  = ~r_crc[7:1];
            w_nxt_tx     = ~r_crc[0];
            w_nxt_fcs_hi = 1'b0;
`else
            w_nxt_state = S_FLAG_CLOSE;
            w_nxt_idx   = 3'd0;
            w_nxt_tx    = LP_FLAG[0];
`endif
          end
        end
`ifdef HDLC_FCS_EN
        S_FCS: begin
          if (r_ones == 3'd5) begin
            w_nxt_tx = 1'b0;
          end else if (r_idx != 3'd7) begin
            w_nxt_idx   = w_idx_inc;
            w_nxt_tx    = r_shift[0];
            w_nxt_shift = {1'b0, r_shift[6:1]};
          end else if (!r_fcs_hi) begin
            w_nxt_idx    = 3'd0;
            w_nxt_shift  = ~r_crc[15:9];
            w_nxt_tx     = ~r_crc[8];
            w_nxt_fcs_hi = 1'b1;
          end else begin
            w_nxt_state = S_FLAG_CLOSE;
            w_nxt_idx   = 3'd0;
            w_nxt_tx    = LP_FLAG[0];
          end
        end
`endif
        S_FLAG_CLOSE: begin
          if (r_idx != 3'd7) begin
            w_nxt_idx  = w_idx_inc;
            w_nxt_tx   = LP_FLAG[w_idx_inc];
            w_nxt_done = (w_idx_inc == 3'd7);
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_valid = 1'b0;
          end
        end
        S_ABORT: begin
          if (r_idx != 3'd7) begin
            w_nxt_idx = w_idx_inc;
            if (w_idx_inc == 3'd7) begin
              w_nxt_aborted = 1'b1;
            end
          end else begin
            w_nxt_state = S_IDLE;
          end
        end
        default: begin
          w_nxt_state = S_IDLE;
          w_nxt_valid = 1'b0;
        end
      endcase
    end
    // The ones run continues across symbol boundaries while stuffing applies; flags and aborts restart it.
    if (w_nxt_state == S_DATA && w_nxt_tx) begin
      w_nxt_ones = r_ones + 3'd1;
    end
`ifdef HDLC_FCS_EN
    if (w_nxt_state == S_FCS && w_nxt_tx) begin
      w_nxt_ones = r_ones + 3'd1;
    end
`endif
  end

  // Datapath and output registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_idx       <= 3'd0;
      r_ones      <= 3'd0;
      r_shift     <= 7'd0;
      r_have_next <= 1'b0;
      r_bytes     <= 8'd0;
      r_tx        <= 1'b1;
      r_rd        <= 1'b0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_idx       <= w_nxt_idx;
      r_ones      <= w_nxt_ones;
      r_shift     <= w_nxt_shift;
      r_have_next <= w_nxt_have;
      r_bytes     <= w_nxt_bytes;
      r_tx        <= w_nxt_tx;
      r_rd        <= w_nxt_rd;
      r_valid     <= w_nxt_valid;
      r_done      <= w_nxt_done;
      r_aborted   <= w_nxt_aborted;
    end
  end

  // Buffer read capture and abort edge detection.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_rd_d    <= 1'b0;
      r_hold    <= 8'h00;
      r_abort_q <= 1'b0;
    end else begin
      r_rd_d    <= r_rd;
      r_abort_q <= Tx_AbortFrame;
      if (r_rd_d) begin
        r_hold <= Tx_Data;
      end
    end
  end

`ifdef HDLC_FCS_EN
  // Frame check sequence state.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_crc    <= CRC_INIT;
      r_fcs_hi <= 1'b0;
    end else begin
      r_crc    <= w_nxt_crc;
      r_fcs_hi <= w_nxt_fcs_hi;
    end
  end
`endif

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// tb/tb_hdlc_tx_framer.sv - directed self-checking bench for hdlc_tx_framer
module tb_hdlc_tx_framer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Tx_Enable;
  logic       Tx_DataAvail;
  logic [7:0] Tx_Data = 8'h00;
  logic       Tx_RdBuff;
  logic       Tx_AbortFrame;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_Done;
  logic       Tx_AbortedTrans;

  always #5 Clk = ~Clk;

  hdlc_tx_framer #(.MAX_BYTES(128), .CRC_INIT(16'hFFFF)) dut (
    .Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_DataAvail(Tx_DataAvail),
    .Tx_Data(Tx_Data), .Tx_RdBuff(Tx_RdBuff), .Tx_AbortFrame(Tx_AbortFrame),
    .Tx(Tx), .Tx_ValidFrame(Tx_ValidFrame), .Tx_Done(Tx_Done),
    .Tx_AbortedTrans(Tx_AbortedTrans)
  );

  // TX buffer model: byte appears the cycle after the pop strobe.
  logic [7:0] mem [0:511];
  int wr_n = 0;
  int rd_n = 0;
  assign Tx_DataAvail = (rd_n < wr_n);
  always @(posedge Clk) begin
    if (Tx_RdBuff) begin
      Tx_Data <= mem[rd_n];
      rd_n    <= rd_n + 1;
    end
  end

  logic cap_tx [1:1100];
  logic cap_valid [1:1100];
  logic cap_done [1:1100];
  logic cap_rd [1:1100];
  logic cap_ab [1:1100];
  int n_done, n_rd, done_at;
  int total = 0;
  int bad = 0;
  string flag = "01111110";
  string e;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] b);
    mem[wr_n] = b;
    wr_n++;
  endtask

  // Pulse Tx_Enable, then record ncyc cycles; cycle k is the k-th cycle after the request.
  task automatic run(input int ncyc, input int abort_at);
    n_done = 0; n_rd = 0; done_at = -1;
    @(negedge Clk);
    Tx_Enable = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge Clk);
      Tx_Enable    = 1'b0;
      cap_tx[k]    = Tx;
      cap_valid[k] = Tx_ValidFrame;
      cap_done[k]  = Tx_Done;
      cap_rd[k]    = Tx_RdBuff;
      cap_ab[k]    = Tx_AbortedTrans;
      if (Tx_Done) begin n_done++; done_at = k; end
      if (Tx_RdBuff) n_rd++;
      if (k == abort_at) Tx_AbortFrame = 1'b1;
    end
  endtask

  function automatic string stream(input int a, input int b);
    string s;
    s = "";
    for (int k = a; k <= b; k++) begin
      if (cap_tx[k]) s = {s, "1"};
      else s = {s, "0"};
    end
    return s;
  endfunction

`ifdef HDLC_FCS_EN
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction
  logic q [$];
  logic [7:0] rx [0:15];
  int ones, nbits;
  logic fin;
  logic [15:0] c;
`endif

  initial begin
    Rst = 1'b0;
    Tx_Enable = 1'b0;
    Tx_AbortFrame = 1'b0;
    repeat (3) @(negedge Clk);
    chk_bit("rst_tx", Tx, 1'b1);
    chk_bit("rst_valid", Tx_ValidFrame, 1'b0);
    chk_bit("rst_rd", Tx_RdBuff, 1'b0);
    chk_bit("rst_done", Tx_Done, 1'b0);
    chk_bit("rst_aborted", Tx_AbortedTrans, 1'b0);
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    chk_bit("idle_tx", Tx, 1'b1);

`ifndef HDLC_FCS_EN
    // Single byte 0x81.
    load(8'h81);
    run(26, 0);
    e = {flag, "10000001", flag, "11"};
    chk_str("t2_stream", stream(1, 26), e);
    chk("t2_rd_pulses", n_rd, 1);
    chk_bit("t2_rd_first", cap_rd[1], 1'b1);
    chk("t2_done_cnt", n_done, 1);
    chk("t2_done_at", done_at, 24);
    chk_bit("t2_valid_1", cap_valid[1], 1'b1);
    chk_bit("t2_valid_24", cap_valid[24], 1'b1);
    chk_bit("t2_valid_25", cap_valid[25], 1'b0);

    // Zero insertion across 0xFF, 0x01.
    load(8'hFF);
    load(8'h01);
    run(35, 0);
    e = {flag, "11111011110000000", flag, "11"};
    chk_str("t3_stream", stream(1, 35), e);
    chk("t3_rd_pulses", n_rd, 2);
    chk_bit("t3_rd_shifted", cap_rd[16], 1'b1);
    chk("t3_done_at", done_at, 33);
`endif

    // Abort during the second data byte.
    load(8'h55);
    load(8'h33);
    run(30, 19);
    e = {flag, "10101010", "110", "01111111", "111"};
    chk_str("t5_stream", stream(1, 30), e);
    chk_bit("t5_valid_19", cap_valid[19], 1'b1);
    chk_bit("t5_valid_20", cap_valid[20], 1'b0);
    chk_bit("t5_ab_26", cap_ab[26], 1'b0);
    chk_bit("t5_ab_27", cap_ab[27], 1'b1);
    chk("t5_done_cnt", n_done, 0);
    chk("t5_rd_pulses", n_rd, 2);
    Tx_AbortFrame = 1'b0;
    repeat (2) @(negedge Clk);

    // Abort request while idle has no effect.
    Tx_AbortFrame = 1'b1;
    repeat (3) @(negedge Clk);
    chk_bit("idle_abort_tx", Tx, 1'b1);
    chk_bit("idle_abort_valid", Tx_ValidFrame, 1'b0);
    chk_bit("idle_abort_flag_kept", Tx_AbortedTrans, 1'b1);
    Tx_AbortFrame = 1'b0;

    // Next frame start clears the aborted flag.
    load(8'h3C);
    run(2, 0);
    chk_bit("t5_ab_cleared", cap_ab[1], 1'b0);
    chk_bit("t5_new_valid", cap_valid[1], 1'b1);
    repeat (80) @(negedge Clk);
    chk_bit("t5_new_idle", Tx_ValidFrame, 1'b0);

`ifdef HDLC_FCS_EN
    // FCS over 0x01, 0x02 checked by a receive-side model on the captured line.
    load(8'h01);
    load(8'h02);
    run(90, 0);
    chk_str("t4_open_flag", stream(1, 8), flag);
    ones = 0; fin = 1'b0;
    q.delete();
    for (int k = 9; k <= 90; k++) begin
      if (!fin) begin
        if (ones == 5) begin
          if (cap_tx[k]) fin = 1'b1;
          else ones = 0;
        end else begin
          q.push_back(cap_tx[k]);
          ones = cap_tx[k] ? ones + 1 : 0;
        end
      end
    end
    chk_bit("t4_close_seen", fin, 1'b1);
    nbits = q.size() - 6;
    chk("t4_bits", nbits, 32);
    for (int i = 0; i < 32; i++) rx[i / 8][i % 8] = q[i];
    chk("t4_frame_size", nbits / 8 - 2, 2);
    c = crc_model(crc_model(16'hFFFF, 8'h01), 8'h02);
    chk("t4_fcs", int'({rx[3], rx[2]}), int'(~c));
    c = 16'hFFFF;
    for (int i = 0; i < 4; i++) c = crc_model(c, rx[i]);
    chk("t4_residue", int'(c), int'(16'hF0B8));
    chk("t4_done_cnt", n_done, 1);
`else
    // Frame length limit: 130 bytes queued, 128 sent.
    for (int i = 0; i < 130; i++) load(8'h00);
    run(1045, 0);
    chk("t6_rd_pulses", n_rd, 128);
    chk("t6_done_at", done_at, 1040);
    chk_str("t6_close_flag", stream(1033, 1040), flag);
    chk_bit("t6_valid_after", cap_valid[1041], 1'b0);
    chk("t6_left", wr_n - rd_n, 2);
`endif

    // Asynchronous reset in the middle of a frame, during a pop strobe.
    load(8'hA5);
    load(8'h5A);
    run(15, 0);
    chk_bit("t1_rd_before", Tx_RdBuff, 1'b1);
    chk_bit("t1_valid_before", Tx_ValidFrame, 1'b1);
    Rst = 1'b0;
    #1;
    chk_bit("t1_tx", Tx, 1'b1);
    chk_bit("t1_valid", Tx_ValidFrame, 1'b0);
    chk_bit("t1_rd", Tx_RdBuff, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    repeat (4) @(negedge Clk);
    chk_bit("t1_idle_tx", Tx, 1'b1);
    chk_bit("t1_idle_valid", Tx_ValidFrame, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
